router_wght: RTL and testbench

ROUTER_WGHT -- requirements
Module: router_wght

---
 rtl/router_wght_if.sv | 36 +++
 rtl/router_wght.sv | 101 ++++++++++
 tb/tb_router_wght.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_wght_if.sv
// Handshake bundle of one weight router: two src ports in, two dst ports out.
// slave = router side, master = the environment (local producer/consumer and neighbour).
interface router_wght_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  ready_src_port_0;
  logic [DATA_WIDTH-1:0] data_src_port_0;
  logic                  enable_src_port_0;
  logic                  ready_src_port_1;
  logic [DATA_WIDTH-1:0] data_src_port_1;
  logic                  enable_src_port_1;
  logic                  ready_dst_port_0;
  logic [DATA_WIDTH-1:0] data_dst_port_0;
  logic                  enable_dst_port_0;
  logic                  ready_dst_port_1;
  logic [DATA_WIDTH-1:0] data_dst_port_1;
  logic                  enable_dst_port_1;

  modport slave (
    output ready_src_port_0, ready_src_port_1,
    output data_dst_port_0, enable_dst_port_0,
    output data_dst_port_1, enable_dst_port_1,
    input  data_src_port_0, enable_src_port_0,
    input  data_src_port_1, enable_src_port_1,
    input  ready_dst_port_0, ready_dst_port_1
  );

  modport master (
    input  ready_src_port_0, ready_src_port_1,
    input  data_dst_port_0, enable_dst_port_0,
    input  data_dst_port_1, enable_dst_port_1,
    output data_src_port_0, enable_src_port_0,
    output data_src_port_1, enable_src_port_1,
    output ready_dst_port_0, ready_dst_port_1
  );
endinterface

// File: rtl/router_wght.sv
// Weight router: master broadcasts local src0 to both dst stages, slave forwards neighbour src1 to dst0.
// One register stage per dst port (1-cycle latency); master src0 stalls unless both stages can accept.
module router_wght #(
  parameter int DATA_WIDTH = 8,
  parameter int FULL_PORTS = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          router_mode_i,
  router_wght_if.slave  bus
);

  typedef enum logic {
    MODE_MASTER = 1'b0,
    MODE_SLAVE  = 1'b1
  } mode_e;

  mode_e                 mode;
  logic [FULL_PORTS-1:0] dst_rdy;
  logic [FULL_PORTS-1:0] can_accept;
  logic [FULL_PORTS-1:0] stage_vld;
  logic [FULL_PORTS-1:0] stage_vld_nxt;
  logic [DATA_WIDTH-1:0] stage_dat     [FULL_PORTS];
  logic [DATA_WIDTH-1:0] stage_dat_nxt [FULL_PORTS];
  logic                  src0_rdy;
  logic                  src1_rdy;
  logic                  src0_xfer;
  logic                  src1_xfer;

  assign mode       = mode_e'(router_mode_i);
  assign dst_rdy    = {bus.ready_dst_port_1, bus.ready_dst_port_0};
  assign can_accept = ~stage_vld | dst_rdy;

  // Mode steers the src readies combinationally; stage contents are untouched by a mode change.
  always_comb begin
    src0_rdy = 1'b0;
    src1_rdy = 1'b0;
    unique case (mode)
      MODE_MASTER: src0_rdy = can_accept[0] & can_accept[1];
      MODE_SLAVE:  src1_rdy = can_accept[0];
      default: ;
    endcase
  end

  assign src0_xfer = bus.enable_src_port_0 & src0_rdy;
  assign src1_xfer = bus.enable_src_port_1 & src1_rdy;

  // A stage that can accept always reloads, so an idle slot clears to valid=0/data=0.
  always_comb begin
    stage_vld_nxt = stage_vld;
    for (int i = 0; i < FULL_PORTS; i++) begin
      stage_dat_nxt[i] = stage_dat[i];
    end

    if (can_accept[0]) begin
      stage_vld_nxt[0] = src0_xfer | src1_xfer;
      if (src0_xfer) begin
        stage_dat_nxt[0] = bus.data_src_port_0;
      end else if (src1_xfer) begin
        stage_dat_nxt[0] = bus.data_src_port_1;
      end else begin
        stage_dat_nxt[0] = '0;
      end
    end

    // Stage 1 only ever carries the master broadcast; a slave never back-forwards.
    if (can_accept[1]) begin
      stage_vld_nxt[1] = src0_xfer;
      stage_dat_nxt[1] = src0_xfer ? bus.data_src_port_0 : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_vld <= '0;
      for (int i = 0; i < FULL_PORTS; i++) begin
        stage_dat[i] <= '0;
      end
    end else begin
      stage_vld <= stage_vld_nxt;
      for (int i = 0; i < FULL_PORTS; i++) begin
        stage_dat[i] <= stage_dat_nxt[i];
      end
    end
  end

  assign bus.ready_src_port_0  = src0_rdy;
  assign bus.ready_src_port_1  = src1_rdy;
  assign bus.enable_dst_port_0 = stage_vld[0];
  assign bus.data_dst_port_0   = stage_dat[0];
  assign bus.enable_dst_port_1 = stage_vld[1];
  assign bus.data_dst_port_1   = stage_dat[1];

  a_one_source: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(src0_xfer && src1_xfer));
  a_idle_zero0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !stage_vld[0] |-> (stage_dat[0] == '0));
  a_idle_zero1: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !stage_vld[1] |-> (stage_dat[1] == '0));

endmodule

// File: tb/tb_router_wght.sv
// Two cross-coupled routers (A.dst1->B.src1, B.dst1->A.src1) driven by directed steps and random traffic.
// Random traffic is scored with per-consumer word queues and the handshake rules.
module tb_router_wght;
  logic clk_i;
  logic rst_ni;
  logic mode_a;
  logic mode_b;

  router_wght_if #(.DATA_WIDTH(8)) ifa ();
  router_wght_if #(.DATA_WIDTH(8)) ifb ();

  router_wght #(.DATA_WIDTH(8), .FULL_PORTS(2)) u_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .router_mode_i(mode_a), .bus(ifa));
  router_wght #(.DATA_WIDTH(8), .FULL_PORTS(2)) u_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .router_mode_i(mode_b), .bus(ifb));

  assign ifb.data_src_port_1   = ifa.data_dst_port_1;
  assign ifb.enable_src_port_1 = ifa.enable_dst_port_1;
  assign ifa.ready_dst_port_1  = ifb.ready_src_port_1;
  assign ifa.data_src_port_1   = ifb.data_dst_port_1;
  assign ifa.enable_src_port_1 = ifb.enable_dst_port_1;
  assign ifb.ready_dst_port_1  = ifa.ready_src_port_1;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  // model state
  logic [7:0] qm[$];
  logic [7:0] qs[$];
  bit         pend;
  logic [7:0] pend_w;
  bit         acc_last;
  bit         cur_en;
  logic [7:0] cur_dat;
  bit         hold0[2], hold1[2];
  logic [7:0] hd0[2], hd1[2];

  // snapshot
  logic       en0[2], en1[2], rd0[2], rs0[2], rs1[2], es0[2];
  logic [7:0] d0[2], d1[2], ds0[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic snap();
    en0[0] = ifa.enable_dst_port_0; d0[0] = ifa.data_dst_port_0; rd0[0] = ifa.ready_dst_port_0;
    en1[0] = ifa.enable_dst_port_1; d1[0] = ifa.data_dst_port_1;
    rs0[0] = ifa.ready_src_port_0;  rs1[0] = ifa.ready_src_port_1;
    es0[0] = ifa.enable_src_port_0; ds0[0] = ifa.data_src_port_0;
    en0[1] = ifb.enable_dst_port_0; d0[1] = ifb.data_dst_port_0; rd0[1] = ifb.ready_dst_port_0;
    en1[1] = ifb.enable_dst_port_1; d1[1] = ifb.data_dst_port_1;
    rs0[1] = ifb.ready_src_port_0;  rs1[1] = ifb.ready_src_port_1;
    es0[1] = ifb.enable_src_port_0; ds0[1] = ifb.data_src_port_0;
  endtask

  task automatic chk_all_zero(input string tag);
    snap();
    for (int r = 0; r < 2; r++) begin
      chk({tag, "_en0"}, en0[r], 0);
      chk({tag, "_dat0"}, d0[r], 0);
      chk({tag, "_en1"}, en1[r], 0);
      chk({tag, "_dat1"}, d1[r], 0);
    end
  endtask

  task automatic clear_model();
    qm.delete();
    qs.delete();
    pend = 0; acc_last = 0; cur_en = 0; cur_dat = '0;
    for (int r = 0; r < 2; r++) begin
      hold0[r] = 0; hold1[r] = 0;
    end
  endtask

  task automatic zero_inputs();
    ifa.data_src_port_0 = '0; ifa.enable_src_port_0 = 0; ifa.ready_dst_port_0 = 0;
    ifb.data_src_port_0 = '0; ifb.enable_src_port_0 = 0; ifb.ready_dst_port_0 = 0;
  endtask

  task automatic do_reset();
    rst_ni = 0;
    zero_inputs();
    clear_model();
    tick();
    tick();
    rst_ni = 1;
  endtask

  task automatic drive(input int mi, input bit send);
    if (!(cur_en && !acc_last)) begin
      cur_en  = send && ($urandom_range(0, 3) != 0);
      cur_dat = 8'($urandom);
    end
    if (mi == 0) begin
      ifa.enable_src_port_0 = cur_en;  ifa.data_src_port_0 = cur_dat;
      ifb.enable_src_port_0 = 1'($urandom_range(0, 1)); ifb.data_src_port_0 = 8'($urandom);
    end else begin
      ifb.enable_src_port_0 = cur_en;  ifb.data_src_port_0 = cur_dat;
      ifa.enable_src_port_0 = 1'($urandom_range(0, 1)); ifa.data_src_port_0 = 8'($urandom);
    end
    ifa.ready_dst_port_0 = send ? ($urandom_range(0, 9) < 7) : 1'b1;
    ifb.ready_dst_port_0 = send ? ($urandom_range(0, 9) < 7) : 1'b1;
  endtask

  task automatic score(input int mi);
    int   si = 1 - mi;
    logic exp_rdy;
    bit   acc;
    #1;
    snap();
    chk("mst_rdy_src1", rs1[mi], 0);
    chk("slv_rdy_src0", rs0[si], 0);
    exp_rdy = (!en0[mi] || rd0[mi]) && (!en1[mi] || rs1[si]);
    chk("mst_rdy_src0", rs0[mi], exp_rdy);
    chk("slv_rdy_src1", rs1[si], !en0[si] || rd0[si]);
    chk("slv_dst1_idle", en1[si], 0);
    for (int r = 0; r < 2; r++) begin
      if (!en0[r]) chk("idle_dat0", d0[r], 0);
      if (!en1[r]) chk("idle_dat1", d1[r], 0);
      if (hold0[r]) begin
        chk("hold_en0", en0[r], 1);
        chk("hold_dat0", d0[r], hd0[r]);
      end
      if (hold1[r]) begin
        chk("hold_en1", en1[r], 1);
        chk("hold_dat1", d1[r], hd1[r]);
      end
    end
    if (pend) begin
      chk("latency_en", en0[mi], 1);
      chk("latency_dat", d0[mi], pend_w);
    end
    if (en0[mi] && rd0[mi]) chk("mst_word", d0[mi], (qm.size() != 0) ? 32'(qm.pop_front()) : 32'h100);
    if (en0[si] && rd0[si]) chk("slv_word", d0[si], (qs.size() != 0) ? 32'(qs.pop_front()) : 32'h100);
    for (int r = 0; r < 2; r++) begin
      hold0[r] = en0[r] && !rd0[r];  hd0[r] = d0[r];
      hold1[r] = en1[r] && !rs1[1-r]; hd1[r] = d1[r];
    end
    acc = es0[mi] && rs0[mi];
    if (acc) begin
      qm.push_back(ds0[mi]);
      qs.push_back(ds0[mi]);
    end
    pend     = acc;
    pend_w   = ds0[mi];
    acc_last = acc;
    tick();
  endtask

  initial begin
    logic [7:0] got[$];
    logic [7:0] exp38[3];
    int         mi;

    rst_ni = 0;
    mode_a = 0;
    mode_b = 0;
    zero_inputs();
    clear_model();
    @(negedge clk_i);
    chk_all_zero("reset");

    // both master, nothing offered, consumers stalled
    ifa.data_src_port_0 = 8'd10;
    ifb.data_src_port_0 = 8'd20;
    rst_ni = 1;
    tick(); tick(); tick();
    chk("idle_a_dst0", ifa.data_dst_port_0, 0);
    chk("idle_b_dst0", ifb.data_dst_port_0, 0);
    chk("idle_a_en0", ifa.enable_dst_port_0, 0);

    // both master, broadcast
    ifa.enable_src_port_0 = 1; ifb.enable_src_port_0 = 1;
    ifa.ready_dst_port_0  = 1; ifb.ready_dst_port_0  = 1;
    #1;
    chk("mm_a_rdy_src0", ifa.ready_src_port_0, 1);
    chk("mm_b_rdy_src0", ifb.ready_src_port_0, 1);
    tick();
    chk("mm_a_dst0", ifa.data_dst_port_0, 10);
    chk("mm_b_dst0", ifb.data_dst_port_0, 20);
    chk("mm_a_dst1", ifa.data_dst_port_1, 10);
    chk("mm_a_en1", ifa.enable_dst_port_1, 1);

    // A master, B slave
    do_reset();
    mode_a = 0; mode_b = 1;
    ifa.data_src_port_0 = 8'd10; ifa.enable_src_port_0 = 1;
    ifb.data_src_port_0 = 8'd20; ifb.enable_src_port_0 = 1;
    ifa.ready_dst_port_0 = 1; ifb.ready_dst_port_0 = 1;
    #1;
    chk("ms_b_rdy_src0", ifb.ready_src_port_0, 0);
    chk("ms_a_rdy_src0", ifa.ready_src_port_0, 1);
    tick();
    chk("ms_a_dst0_c1", ifa.data_dst_port_0, 10);
    tick();
    chk("ms_a_dst0", ifa.data_dst_port_0, 10);
    chk("ms_b_dst0", ifb.data_dst_port_0, 10);
    chk("ms_b_rdy_src0_c2", ifb.ready_src_port_0, 0);

    // mode flip: readies follow immediately, words in flight stay put
    mode_a = 1; mode_b = 0;
    #1;
    chk("flip_a_rdy_src0", ifa.ready_src_port_0, 0);
    chk("flip_a_rdy_src1", ifa.ready_src_port_1, 1);
    chk("flip_b_rdy_src0", ifb.ready_src_port_0, 1);
    chk("flip_b_rdy_src1", ifb.ready_src_port_1, 0);
    tick();
    chk("flip_a_dst1_kept", ifa.data_dst_port_1, 10);
    chk("flip_b_dst0", ifb.data_dst_port_0, 20);

    // A slave, B master
    do_reset();
    mode_a = 1; mode_b = 0;
    ifa.data_src_port_0 = 8'd10; ifa.enable_src_port_0 = 1;
    ifb.data_src_port_0 = 8'd20; ifb.enable_src_port_0 = 1;
    ifa.ready_dst_port_0 = 1; ifb.ready_dst_port_0 = 1;
    #1;
    chk("sm_a_rdy_src0", ifa.ready_src_port_0, 0);
    tick(); tick();
    chk("sm_a_dst0", ifa.data_dst_port_0, 20);
    chk("sm_b_dst0", ifb.data_dst_port_0, 20);

    // master stalled by neighbour: no loss, no duplication
    do_reset();
    mode_a = 0; mode_b = 1;
    ifa.ready_dst_port_0 = 1; ifb.ready_dst_port_0 = 0;
    ifa.data_src_port_0 = 8'h11; ifa.enable_src_port_0 = 1;
    #1;
    chk("stall_rdy_w1", ifa.ready_src_port_0, 1);
    tick();
    chk("stall_a_dst1_w1", ifa.data_dst_port_1, 8'h11);
    ifa.data_src_port_0 = 8'h22;
    #1;
    chk("stall_rdy_w2", ifa.ready_src_port_0, 1);
    tick();
    ifa.data_src_port_0 = 8'h33;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_blocked", ifa.ready_src_port_0, 0);
      tick();
      chk("stall_b_dst0", ifb.data_dst_port_0, 8'h11);
      chk("stall_b_en0", ifb.enable_dst_port_0, 1);
      chk("stall_a_dst1", ifa.data_dst_port_1, 8'h22);
    end
    ifb.ready_dst_port_0 = 1;
    for (int k = 0; k < 6; k++) begin
      bit a_acc;
      #1;
      a_acc = ifa.enable_src_port_0 && ifa.ready_src_port_0;
      if (ifb.enable_dst_port_0 && ifb.ready_dst_port_0) got.push_back(ifb.data_dst_port_0);
      tick();
      if (a_acc) ifa.enable_src_port_0 = 0;
    end
    exp38[0] = 8'h11; exp38[1] = 8'h22; exp38[2] = 8'h33;
    chk("stall_count", got.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("stall_order", (k < got.size()) ? 32'(got[k]) : 32'h100, exp38[k]);
    end

    // random traffic epochs
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      mi = $urandom_range(0, 1);
      mode_a = (mi == 0) ? 1'b0 : 1'b1;
      mode_b = ~mode_a;
      for (int c = 0; c < 150; c++) begin
        drive(mi, 1);
        score(mi);
      end
      for (int c = 0; c < 12; c++) begin
        drive(mi, 0);
        score(mi);
      end
      chk("drain_mst", qm.size(), 0);
      chk("drain_slv", qs.size(), 0);
    end

    // reset in the middle of traffic, then the first post-reset word
    do_reset();
    mode_a = 0; mode_b = 1;
    for (int c = 0; c < 20; c++) begin
      drive(0, 1);
      score(0);
    end
    ifa.ready_dst_port_0 = 0; ifb.ready_dst_port_0 = 0;
    ifa.enable_src_port_0 = 1; ifa.data_src_port_0 = 8'h77;
    tick(); tick();
    #2;
    rst_ni = 0;
    #1;
    chk_all_zero("async_reset");
    clear_model();
    @(negedge clk_i);
    ifa.data_src_port_0 = 8'h5A; ifa.enable_src_port_0 = 1;
    ifa.ready_dst_port_0 = 1; ifb.ready_dst_port_0 = 1;
    rst_ni = 1;
    #1;
    chk("post_rst_rdy", ifa.ready_src_port_0, 1);
    tick();
    chk("post_rst_en", ifa.enable_dst_port_0, 1);
    chk("post_rst_dat", ifa.data_dst_port_0, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
